// File: rtl/layer_engine_arbiter.sv
// Two-requester arbiter in front of a shared sequential MAC layer engine.
// Registers the winning input vector, launches the engine, captures its result and returns a done pulse.
module layer_engine_arbiter #(
    parameter int N_ELEM         = 256,
    parameter int ELEM_W         = 16,
    parameter int TIMEOUT_CYCLES = 70000,
    parameter int CNT_W          = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0,
    input  logic [N_ELEM*ELEM_W-1:0]   in0_flat,
    output logic                       done0,
    input  logic                       req1,
    input  logic [N_ELEM*ELEM_W-1:0]   in1_flat,
    output logic                       done1,
    output logic [N_ELEM*ELEM_W-1:0]   resp_flat,
    output logic                       eng_start,
    output logic [N_ELEM*ELEM_W-1:0]   eng_input_flat,
    input  logic [N_ELEM*ELEM_W-1:0]   eng_output_flat,
    input  logic                       eng_done,
    output logic                       busy,
    output logic                       owner,
    output logic                       timeout_err
);

    localparam int VEC_W = N_ELEM * ELEM_W;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HALT} state_t;

    state_t             state, state_n;
    logic               pend0, pend1, pend0_n, pend1_n;
    logic               last_owner, last_owner_n;
    logic               owner_n, busy_n, eng_start_n;
    logic               done0_n, done1_n, timeout_err_n;
    logic [VEC_W-1:0]   eng_input_n, resp_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               eff0, eff1, accept0, accept1, sel;

    assign eff0    = pend0 | req0;
    assign eff1    = pend1 | req1;
    // A requester cannot queue a second request behind its own running transaction.
    assign accept0 = (state != HALT) && !(busy && (owner == 1'b0));
    assign accept1 = (state != HALT) && !(busy && (owner == 1'b1));

    always_comb begin
        state_n       = state;
        pend0_n       = pend0 | (req0 & accept0);
        pend1_n       = pend1 | (req1 & accept1);
        last_owner_n  = last_owner;
        owner_n       = owner;
        busy_n        = busy;
        eng_start_n   = 1'b0;
        done0_n       = 1'b0;
        done1_n       = 1'b0;
        timeout_err_n = timeout_err;
        eng_input_n   = eng_input_flat;
        resp_n        = resp_flat;
        cnt_n         = cnt;
        sel           = 1'b0;

        case (state)
            IDLE: begin
                if (eff0 | eff1) begin
                    sel         = (eff0 & eff1) ? ~last_owner : eff1;
                    eng_input_n = sel ? in1_flat : in0_flat;
                    owner_n     = sel;
                    busy_n      = 1'b1;
                    eng_start_n = 1'b1;
                    state_n     = LAUNCH;
                    if (sel) begin
                        pend1_n = 1'b0;
                    end else begin
                        pend0_n = 1'b0;
                    end
                end
            end
            LAUNCH: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    resp_n       = eng_output_flat;
                    done0_n      = ~owner;
                    done1_n      = owner;
                    busy_n       = 1'b0;
                    last_owner_n = owner;
                    state_n      = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_n = 1'b1;
                    busy_n        = 1'b0;
                    state_n       = HALT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pend0          <= 1'b0;
            pend1          <= 1'b0;
            last_owner     <= 1'b1;
            owner          <= 1'b0;
            busy           <= 1'b0;
            eng_start      <= 1'b0;
            done0          <= 1'b0;
            done1          <= 1'b0;
            timeout_err    <= 1'b0;
            eng_input_flat <= '0;
            resp_flat      <= '0;
            cnt            <= '0;
        end else begin
            state          <= state_n;
            pend0          <= pend0_n;
            pend1          <= pend1_n;
            last_owner     <= last_owner_n;
            owner          <= owner_n;
            busy           <= busy_n;
            eng_start      <= eng_start_n;
            done0          <= done0_n;
            done1          <= done1_n;
            timeout_err    <= timeout_err_n;
            eng_input_flat <= eng_input_n;
            resp_flat      <= resp_n;
            cnt            <= cnt_n;
        end
    end

endmodule

// File: tb/tb_layer_engine_arbiter.sv
// Randomized scoreboard bench for layer_engine_arbiter with a stub engine that doubles every element.
// Grant order is predicted per transaction from the round-robin rules, not from cycle-level state.
module tb_layer_engine_arbiter;

    localparam int N_ELEM = 256;
    localparam int ELEM_W = 16;
    localparam int VEC_W  = N_ELEM * ELEM_W;
    localparam int TMO    = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [VEC_W-1:0] in0_flat, in1_flat;
    logic             done0, done1;
    logic [VEC_W-1:0] resp_flat, eng_input_flat, eng_output_flat;
    logic             eng_start, eng_done, busy, owner, timeout_err;

    layer_engine_arbiter #(
        .N_ELEM(N_ELEM), .ELEM_W(ELEM_W), .TIMEOUT_CYCLES(TMO), .CNT_W(5)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .in0_flat(in0_flat), .done0(done0),
        .req1(req1), .in1_flat(in1_flat), .done1(done1),
        .resp_flat(resp_flat), .eng_start(eng_start), .eng_input_flat(eng_input_flat),
        .eng_output_flat(eng_output_flat), .eng_done(eng_done),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int done_target = 0;
    int stub_lat = 3;
    int stub_cnt = -1;
    bit stub_en = 1'b1;
    bit spur = 1'b0;
    logic model_last = 1'b1;
    logic [VEC_W-1:0] last_resp = '0;

    int               exp_id_q[$];
    logic [VEC_W-1:0] exp_resp_q[$];
    logic [VEC_W-1:0] exp_in_q[$];
    int               exp_own_q[$];

    // Reference engine: each signed Q8.8 element multiplied by 2, wrapping to 16 bits.
    function automatic logic [VEC_W-1:0] engine_fn(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0] r;
        for (int i = 0; i < N_ELEM; i++) begin
            r[i*ELEM_W +: ELEM_W] = 16'(int'(v[i*ELEM_W +: ELEM_W]) * 2);
        end
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] r;
        for (int i = 0; i < VEC_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkVector(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        int idx;
        tests++;
        if (act !== exp) begin
            fails++;
            idx = 0;
            for (int i = N_ELEM - 1; i >= 0; i--)
                if (act[i*ELEM_W +: ELEM_W] !== exp[i*ELEM_W +: ELEM_W]) idx = i;
            $display("[TB] FAIL %s: element %0d got 0x%0h, expected 0x%0h", name, idx,
                     act[idx*ELEM_W +: ELEM_W], exp[idx*ELEM_W +: ELEM_W]);
        end
    endtask

    // Stub engine: returns engine_fn(input) stub_lat cycles after seeing start, unless disabled.
    initial begin
        eng_done = 1'b0;
        eng_output_flat = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (rst) begin
                stub_cnt = -1;
            end else begin
                if (stub_cnt == 0) begin
                    eng_output_flat = engine_fn(eng_input_flat);
                    eng_done = 1'b1;
                    stub_cnt = -1;
                end else if (stub_cnt > 0) begin
                    stub_cnt--;
                end
                if (eng_start && stub_en) stub_cnt = stub_lat;
                if (spur) begin
                    eng_output_flat = rand_vec();
                    eng_done = 1'b1;
                    spur = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT launches the engine or signals completion.
    initial begin
        int id;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (eng_start) begin
                    if (exp_in_q.size() == 0) begin
                        tests++; fails++;
                        $display("[TB] FAIL unexpected eng_start: owner %0d", owner);
                    end else begin
                        checkVector("eng_input", eng_input_flat, exp_in_q.pop_front());
                        checkOutput("start owner", 32'(owner), 32'(exp_own_q.pop_front()));
                        checkOutput("busy at start", 32'(busy), 1);
                    end
                end
                if (done0 || done1) begin
                    if (exp_id_q.size() == 0) begin
                        tests++; fails++;
                        $display("[TB] FAIL unexpected done: done0 %0d done1 %0d, expected none", done0, done1);
                    end else begin
                        id = exp_id_q.pop_front();
                        checkOutput("done0", 32'(done0), 32'(id == 0));
                        checkOutput("done1", 32'(done1), 32'(id == 1));
                        checkVector("resp", resp_flat, exp_resp_q.pop_front());
                        checkOutput("busy at done", 32'(busy), 0);
                    end
                    done_seen++;
                end
            end
        end
    end

    task automatic expectTxn(input int x, input bit with_done);
        logic [VEC_W-1:0] v;
        v = x ? in1_flat : in0_flat;
        exp_in_q.push_back(v);
        exp_own_q.push_back(x);
        if (with_done) begin
            exp_id_q.push_back(x);
            exp_resp_q.push_back(engine_fn(v));
            last_resp = engine_fn(v);
            done_target++;
        end
    endtask

    task automatic pulse(input bit p0, input bit p1);
        req0 = p0;
        req1 = p1;
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (done_seen < done_target && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("completion wait", 32'(done_seen), 32'(done_target));
        done_seen = done_target;
    endtask

    // mode 0: single request; 1: simultaneous tie; 2: r first, the other while r is in flight.
    task automatic applyStimulus(input int mode, input int r, input logic [VEC_W-1:0] d0,
                                 input logic [VEC_W-1:0] d1, input int lat);
        int first;
        stub_lat = lat;
        in0_flat = d0;
        in1_flat = d1;
        if (mode == 0) begin
            expectTxn(r, 1'b1);
            model_last = 1'(r);
            pulse(r == 0, r == 1);
        end else if (mode == 1) begin
            first = int'(!model_last);
            expectTxn(first, 1'b1);
            expectTxn(1 - first, 1'b1);
            model_last = 1'(1 - first);
            pulse(1'b1, 1'b1);
        end else begin
            expectTxn(r, 1'b1);
            expectTxn(1 - r, 1'b1);
            model_last = 1'(1 - r);
            pulse(r == 0, r == 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pulse(r == 1, r == 0);
        end
        waitDone();
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [VEC_W-1:0] d0, d1;
        int e;
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        in0_flat = '0;
        in1_flat = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset owner", 32'(owner), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset eng_start", 32'(eng_start), 0);
        checkOutput("reset done", 32'({done1, done0}), 0);
        checkOutput("reset timeout_err", 32'(timeout_err), 0);
        checkVector("reset resp", resp_flat, '0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        $display("[TB] tie after reset");
        d0 = rand_vec(); d0[15:0] = 16'h0100;
        d1 = rand_vec(); d1[15:0] = 16'h0001;
        applyStimulus(1, 0, d0, d1, 10);
        checkOutput("tie resp elem0", 32'(resp_flat[15:0]), 32'h0002);

        $display("[TB] single request");
        applyStimulus(0, 0, d0, rand_vec(), 10);
        checkOutput("single resp elem0", 32'(resp_flat[15:0]), 32'h0200);
        checkOutput("single busy after", 32'(busy), 0);

        $display("[TB] spurious completion in IDLE");
        spur = 1'b1;
        repeat (4) @(negedge clk);
        checkVector("spurious resp unchanged", resp_flat, last_resp);
        checkOutput("spurious busy", 32'(busy), 0);
        applyStimulus(0, 1, rand_vec(), rand_vec(), 2);

        $display("[TB] random rounds");
        for (int k = 0; k < 40; k++) begin
            applyStimulus($urandom_range(0, 2), $urandom_range(0, 1), rand_vec(), rand_vec(),
                          $urandom_range(0, 12));
        end

        $display("[TB] reset mid-WAIT");
        stub_lat = 40;
        in0_flat = rand_vec();
        expectTxn(0, 1'b0);
        pulse(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        pulse(1'b0, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset busy", 32'(busy), 0);
        checkOutput("async reset owner", 32'(owner), 0);
        checkOutput("async reset start", 32'(eng_start), 0);
        checkVector("async reset eng_input", eng_input_flat, '0);
        checkVector("async reset resp", resp_flat, '0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        model_last = 1'b1;
        last_resp = '0;
        repeat (8) @(negedge clk);
        checkOutput("pend cleared by reset", 32'(busy), 0);
        applyStimulus(0, 1, rand_vec(), rand_vec(), 5);

        $display("[TB] timeout");
        stub_en = 1'b0;
        in0_flat = rand_vec();
        expectTxn(0, 1'b0);
        pulse(1'b1, 1'b0);
        checkOutput("timeout launch start", 32'(eng_start), 1);
        e = 0;
        while (!timeout_err && e < 60) begin
            @(negedge clk);
            e++;
        end
        checkOutput("timeout latency", 32'(e), 21);
        checkOutput("timeout busy", 32'(busy), 0);
        in1_flat = rand_vec();
        pulse(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("halt busy", 32'(busy), 0);
        checkOutput("halt timeout_err sticky", 32'(timeout_err), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("reset clears timeout_err", 32'(timeout_err), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        stub_en = 1'b1;
        model_last = 1'b1;
        applyStimulus(1, 0, rand_vec(), rand_vec(), 4);

        repeat (5) @(negedge clk);
        checkOutput("leftover expectations", 32'(exp_id_q.size() + exp_in_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer_engine_arbiter.md
Name: layer_engine_arbiter

Overview:
- Shares one sequential MAC layer engine between two requesters: requester 0 is the generator path and requester 1 is the discriminator path.
- The engine uses a start/done handshake and flattened 256x16-bit input and output buses.
- This block registers the granted request's input vector, launches the engine, and watches for completion with a timeout.
- On completion it captures the result and returns a done pulse to the owner. Ties are broken round-robin.

Parameters:
- N_ELEM, 256, vector elements per transaction
- ELEM_W, 16, bits per element (signed Q8.8)
- TIMEOUT_CYCLES, 70000, maximum WAIT cycles before a fatal timeout
- CNT_W, 17, width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT_CYCLES)

Ports:
- clk, in, 1, clock
- rst, in, 1, reset: asynchronous, active-high
- req0, in, 1, requester 0 single-cycle request pulse
- in0_flat, in, N_ELEM*ELEM_W, requester 0 input vector; must be stable while the request is pending
- done0, out, 1, one-cycle completion pulse to requester 0
- req1, in, 1, requester 1 single-cycle request pulse
- in1_flat, in, N_ELEM*ELEM_W, requester 1 input vector; same stability rule
- done1, out, 1, one-cycle completion pulse to requester 1
- resp_flat, out, N_ELEM*ELEM_W, registered engine result; valid from the done pulse until the next completion
- eng_start, out, 1, one-cycle engine start pulse
- eng_input_flat, out, N_ELEM*ELEM_W, registered engine input vector
- eng_output_flat, in, N_ELEM*ELEM_W, engine result bus
- eng_done, in, 1, engine completion pulse
- busy, out, 1, high from grant until completion
- owner, out, 1, current or most recent grantee
- timeout_err, out, 1, sticky fatal error flag

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While rst is high:
  - state=IDLE.
  - pend0=pend1=0.
  - last_owner=1, so requester 0 wins the first tie.
  - owner=0, busy=0, eng_start=0, done0=done1=0, timeout_err=0.
  - eng_input_flat=0, resp_flat=0, timeout counter=0.
  - The engine shares rst, so a reset mid-operation aborts both blocks cleanly. No done pulse is issued for an aborted transaction.
- Pending bits:
  - reqN high at an edge sets pendN, unless that request is granted at the same edge.
  - A reqN pulse while pendN=1, or while requester N owns the engine, is ignored. There is no queueing beyond one outstanding request per requester.
- Effective request: effN = pendN | reqN.
- IDLE:
  - If only eff0 is high, grant requester 0. If only eff1 is high, grant requester 1.
  - If both are high, grant the requester that is not last_owner.
  - On grant (edge k):
    - eng_input_flat <= inX_flat
    - owner <= X
    - pendX <= 0
    - busy <= 1
    - eng_start <= 1
    - state <= LAUNCH
  - If neither is high, stay in IDLE.
- LAUNCH: lasts exactly one cycle. At edge k+1: eng_start <= 0, counter <= 0, state <= WAIT.
- WAIT:
  - If eng_done is high at edge j:
    - resp_flat <= eng_output_flat
    - doneX <= 1 for exactly one cycle (X = owner)
    - busy <= 0
    - last_owner <= owner
    - state <= IDLE
  - Otherwise the counter increments.
  - If the counter reaches TIMEOUT_CYCLES-1 without eng_done: timeout_err <= 1, busy <= 0, state <= HALT. No done pulse is issued.
- HALT: terminal state. No grants are made and reqN pulses are ignored. Only rst exits HALT.
- Spurious eng_done in IDLE, LAUNCH or HALT is ignored; resp_flat is unchanged.
- Back-to-back:
  - IDLE may grant at edge j+1, immediately after a completion.
  - The minimum grant-to-grant spacing is 3 cycles plus the engine latency.
- A request arriving at the same edge as the owner's completion is held in pend and is considered at the next IDLE edge.
- No arithmetic is performed: vectors pass through unmodified, bit-exact.
- eng_start is never asserted while busy is high outside LAUNCH. This guarantees the engine sees start only when idle.

Test Plan:
- Single request: req0 pulse at edge k with in0 element0=0x0100 → eng_start high for one cycle after edge k, eng_input_flat equals in0_flat. Stub engine returns element0=0x0200 with eng_done 10 cycles later → done0 pulses once, resp_flat element0=0x0200, busy falls, done1 stays 0.
- Tie after reset: req0 and req1 pulse at the same edge → requester 0 served first, then requester 1 granted at the edge after done0. eng_input_flat switches to in1_flat; done1 pulses with engine output 2.
- Fairness: both requesters repeatedly re-pulse immediately after their done → grants alternate 0,1,0,1 over 4 transactions, with no requester served twice consecutively.
- Timeout: TIMEOUT_CYCLES=20, stub never asserts eng_done → timeout_err=1 exactly 20 WAIT cycles after LAUNCH, busy=0, no done pulse. A subsequent req1 produces no eng_start. rst clears timeout_err.
- Reset mid-WAIT: rst asserted 5 cycles into WAIT → all outputs return to reset values asynchronously and pend bits clear. A fresh req1 afterwards completes normally.
- Spurious completion: eng_done pulsed while IDLE → no done pulse, resp_flat unchanged, state stays IDLE.
